// File: rtl/loader_pkg.sv
// Shared types and defaults for the boot loader: FSM states, tx handshake phases, reply bytes.
package loader_pkg;

    typedef enum logic [2:0] {HDR, LOAD, ACK, RUN, ERR} loader_state_t;

    typedef enum logic [1:0] {TX_SEND, TX_GAP, TX_DRAIN, TX_DONE} tx_phase_t;

    localparam logic [7:0] ACK_BYTE_DEF = 8'hAA;
    localparam logic [7:0] ERR_BYTE_DEF = 8'hEE;

endpackage

// File: rtl/byte_packer.sv
// Little-endian 8->32 packer, 1 byte/cycle, word_vld_o one cycle after the 4th byte.
// No backpressure: every strobed byte is taken; clear_i restarts at byte 0 without dropping a concurrent byte.
module byte_packer (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clear_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_dat_i,
    output logic [31:0] word_dat_o,
    output logic        word_vld_o
);

    logic [1:0]  idx_q, idx_d, idx_sel;
    logic [31:0] word_q, word_d;
    logic        vld_q, vld_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_q  <= 2'd0;
            word_q <= 32'd0;
            vld_q  <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
            vld_q  <= vld_d;
        end
    end

    always_comb begin
        idx_sel = clear_i ? 2'd0 : idx_q;
        idx_d   = idx_sel;
        word_d  = word_q;
        vld_d   = 1'b0;
        if (byte_vld_i) begin
            word_d[{idx_sel, 3'b000} +: 8] = byte_dat_i;
            idx_d = idx_sel + 2'd1;
            vld_d = (idx_sel == 2'd3);
        end
    end

    assign word_dat_o = word_q;
    assign word_vld_o = vld_q;

endmodule

// File: rtl/program_loader.sv
// Boot sequencer: header + payload from RX into imem (write 1 cycle after last byte), ACK/ERR reply, then hands RX to the CPU.
// RX has no backpressure; tx_start only fires while tx_busy is low.
module program_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_W   = 15,
    parameter logic [7:0] ACK_BYTE = ACK_BYTE_DEF,
    parameter logic [7:0] ERR_BYTE = ERR_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_ferr,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              cpu_run,
    output logic              cpu_rx_valid,
    output logic [7:0]        cpu_rx_data,
    output logic              load_err
);

    localparam logic [32:0]     MAX_WORDS = 33'd1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    loader_state_t   state_q, state_d;
    tx_phase_t       phase_q, phase_d;
    logic [ADDR_W:0] cnt_q, cnt_d, n_q, n_d, cnt_inc;
    logic            fwd_vld_q;
    logic [7:0]      fwd_dat_q;

    logic        loading, rx_bad, pk_byte_vld, pk_clear, pk_vld;
    logic [31:0] pk_word;
    logic        hdr_zero, hdr_big, in_run, replying;

    assign loading     = (state_q == HDR) || (state_q == LOAD);
    assign in_run      = (state_q == RUN);
    assign replying    = (state_q == ACK) || (state_q == ERR);
    assign rx_bad      = loading && rx_valid && rx_ferr;
    assign pk_byte_vld = loading && rx_valid && !rx_ferr;
    assign hdr_zero    = (pk_word == 32'd0);
    assign hdr_big     = ({1'b0, pk_word} > MAX_WORDS);
    assign cnt_inc     = cnt_q + CNT_ONE;
    // A payload byte may arrive in the same cycle the header word is judged; clear keeps it at index 0.
    assign pk_clear    = (state_q == HDR) && pk_vld && !rx_bad && !hdr_zero && !hdr_big;

    byte_packer u_packer (
        .clk        (clk),
        .rstn       (rstn),
        .clear_i    (pk_clear),
        .byte_vld_i (pk_byte_vld),
        .byte_dat_i (rx_data),
        .word_dat_o (pk_word),
        .word_vld_o (pk_vld)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= HDR;
            phase_q <= TX_SEND;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q     <= '0;
            n_q       <= '0;
            fwd_vld_q <= 1'b0;
            fwd_dat_q <= 8'h00;
        end else begin
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            fwd_vld_q <= in_run && rx_valid;
            if (in_run && rx_valid) begin
                fwd_dat_q <= rx_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        case (state_q)
            HDR: begin
                if (rx_bad) begin
                    state_d = ERR;
                end else if (pk_vld) begin
                    if (hdr_zero) begin
                        state_d = ACK;
                    end else if (hdr_big) begin
                        state_d = ERR;
                    end else begin
                        state_d = LOAD;
                        n_d     = pk_word[ADDR_W:0];
                    end
                end
            end
            LOAD: begin
                if (pk_vld) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == n_q) begin
                        state_d = ACK;
                    end
                end
                if (rx_bad) begin
                    state_d = ERR;
                end
            end
            ACK, ERR: begin
                // One reply byte, then a settle cycle so uart_tx can raise busy before we look again.
                case (phase_q)
                    TX_SEND:  if (!tx_busy) phase_d = TX_GAP;
                    TX_GAP:   phase_d = TX_DRAIN;
                    TX_DRAIN: begin
                        if (!tx_busy) begin
                            phase_d = TX_DONE;
                            if (state_q == ACK) begin
                                state_d = RUN;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        imem_we      = (state_q == LOAD) && pk_vld;
        imem_addr    = cnt_q[ADDR_W-1:0];
        imem_wdata   = pk_word;
        tx_start     = replying && (phase_q == TX_SEND) && !tx_busy;
        tx_data      = 8'h00;
        if (tx_start) begin
            tx_data = (state_q == ERR) ? ERR_BYTE : ACK_BYTE;
        end
        cpu_run      = in_run;
        cpu_rx_valid = fwd_vld_q;
        cpu_rx_data  = fwd_dat_q;
        load_err     = (state_q == ERR);
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed + randomized bench for program_loader against a stream-level reference model.
module tb_program_loader;

    localparam int AW    = 4;
    localparam int MAXW  = 1 << AW;
    localparam int TXLEN = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_ferr = 1'b0;
    logic          tx_busy = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          cpu_run;
    logic          cpu_rx_valid;
    logic [7:0]    cpu_rx_data;
    logic          load_err;

    program_loader #(.ADDR_W(AW)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ferr      (rx_ferr),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .cpu_run      (cpu_run),
        .cpu_rx_valid (cpu_rx_valid),
        .cpu_rx_data  (cpu_rx_data),
        .load_err     (load_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observed traffic, sampled on the falling edge.
    logic [31:0] wq_a[$];
    logic [31:0] wq_d[$];
    logic [7:0]  txq[$];
    logic [7:0]  cpuq[$];
    int          tx_viol = 0;
    int          run_viol = 0;
    int          tx_starts = 0;
    logic        run_prev = 1'b0;

    always @(negedge clk) begin
        if (imem_we) begin
            wq_a.push_back(32'(imem_addr));
            wq_d.push_back(imem_wdata);
        end
        if (tx_start) begin
            txq.push_back(tx_data);
            tx_starts++;
            if (tx_busy) tx_viol++;
        end
        if (cpu_rx_valid) cpuq.push_back(cpu_rx_data);
        if (cpu_run && !run_prev && tx_busy) run_viol++;
        run_prev = cpu_run;
    end

    // uart_tx stand-in: busy for TXLEN cycles starting the cycle after a start pulse.
    int tx_seen = 0;
    int busy_cnt = 0;
    bit force_busy = 1'b0;

    always @(posedge clk) begin
        #1;
        if (tx_starts != tx_seen) begin
            tx_seen  = tx_starts;
            busy_cnt = TXLEN;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        tx_busy = (busy_cnt != 0) || force_busy;
    end

    // Reference model results.
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];
    bit          exp_run;
    logic [7:0]  sq[$];
    logic [7:0]  s1[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset;
        rx_valid = 1'b0;
        rx_ferr  = 1'b0;
        rstn     = 1'b0;
        repeat (2) tick;
        rstn = 1'b1;
        tick;
    endtask

    // Parse a byte stream by the protocol rules: header count, then whole words until done or a framing error.
    task automatic model(input logic [7:0] bq[$], input int fe);
        longint n;
        exp_a.delete();
        exp_d.delete();
        exp_run = 1'b0;
        if (fe >= 0 && fe < 4) return;
        n = longint'(bq[0]) | (longint'(bq[1]) << 8) | (longint'(bq[2]) << 16) | (longint'(bq[3]) << 24);
        if (n == 0) begin
            exp_run = 1'b1;
            return;
        end
        if (n > MAXW) return;
        for (int w = 0; w < int'(n); w++) begin
            int b;
            b = 4 + 4 * w;
            if (fe >= b && fe < b + 4) return;
            exp_a.push_back(32'(w));
            exp_d.push_back({bq[b+3], bq[b+2], bq[b+1], bq[b]});
        end
        exp_run = 1'b1;
    endtask

    task automatic mk_stream(input logic [31:0] hdr, input int nwords, input int extra);
        sq.delete();
        for (int k = 0; k < 4; k++) sq.push_back(hdr[8*k +: 8]);
        for (int k = 0; k < 4 * nwords + extra; k++) sq.push_back(8'($urandom));
    endtask

    task automatic run_scenario(input string tag, input logic [7:0] bq[$], input int fe,
                                input int gapmax, input bit hold);
        int wbase, tbase, cbase, nw, nmin;
        do_reset;
        wbase = wq_a.size();
        tbase = txq.size();
        cbase = cpuq.size();
        model(bq, fe);
        if (hold) force_busy = 1'b1;
        foreach (bq[i]) begin
            rx_valid = 1'b1;
            rx_data  = bq[i];
            rx_ferr  = (i == fe);
            tick;
            rx_valid = 1'b0;
            rx_ferr  = 1'b0;
            if (gapmax > 0) repeat ($urandom_range(0, gapmax)) tick;
        end
        if (hold) begin
            repeat (8) tick;
            chk($sformatf("%s.hold_tx", tag), 64'(txq.size() - tbase), 64'd0);
            chk($sformatf("%s.hold_run", tag), 64'(cpu_run), 64'd0);
            force_busy = 1'b0;
        end
        for (int i = 0; i < 200; i++) begin
            if (cpu_run || load_err) break;
            tick;
        end
        repeat (TXLEN + 6) tick;
        chk($sformatf("%s.cpu_run", tag), 64'(cpu_run), 64'(exp_run));
        chk($sformatf("%s.load_err", tag), 64'(load_err), 64'(!exp_run));
        chk($sformatf("%s.tx_count", tag), 64'(txq.size() - tbase), 64'd1);
        if (txq.size() > tbase)
            chk($sformatf("%s.tx_byte", tag), 64'(txq[tbase]), exp_run ? 64'hAA : 64'hEE);
        nw = wq_a.size() - wbase;
        chk($sformatf("%s.wr_count", tag), 64'(nw), 64'(exp_a.size()));
        nmin = (nw < exp_a.size()) ? nw : exp_a.size();
        for (int k = 0; k < nmin; k++) begin
            chk($sformatf("%s.wr_addr%0d", tag, k), 64'(wq_a[wbase+k]), 64'(exp_a[k]));
            chk($sformatf("%s.wr_data%0d", tag, k), 64'(wq_d[wbase+k]), 64'(exp_d[k]));
        end
        chk($sformatf("%s.no_fwd", tag), 64'(cpuq.size() - cbase), 64'd0);
        chk($sformatf("%s.tx_while_busy", tag), 64'(tx_viol), 64'd0);
        chk($sformatf("%s.run_while_busy", tag), 64'(run_viol), 64'd0);
    endtask

    initial begin
        int wb, kind, n, fe;
        s1 = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};

        #2 rstn = 1'b0;
        #1;
        chk("reset_outputs",
            64'({imem_we, imem_addr, imem_wdata, tx_start, tx_data, cpu_run, cpu_rx_valid, cpu_rx_data, load_err}),
            64'd0);

        run_scenario("s1", s1, -1, 1, 1'b0);

        // Forwarding in RUN, including a byte flagged with a framing error.
        wb = wq_a.size();
        rx_valid = 1'b1; rx_data = 8'h41;
        tick;
        rx_valid = 1'b0;
        chk("s5.fwd_vld", 64'(cpu_rx_valid), 64'd1);
        chk("s5.fwd_dat", 64'(cpu_rx_data), 64'h41);
        tick;
        chk("s5.fwd_pulse", 64'(cpu_rx_valid), 64'd0);
        rx_valid = 1'b1; rx_ferr = 1'b1; rx_data = 8'h99;
        tick;
        rx_valid = 1'b0; rx_ferr = 1'b0;
        chk("s5.fwd_ferr_dat", {63'd0, cpu_rx_valid} << 8 | 64'(cpu_rx_data), 64'h199);
        chk("s5.still_run", 64'({cpu_run, load_err}), 64'b10);
        chk("s5.no_imem_we", 64'(wq_a.size() - wb), 64'd0);
        rstn = 1'b0;
        #1;
        chk("async_run_drop", 64'(cpu_run), 64'd0);

        mk_stream(32'd0, 0, 0);
        run_scenario("s2_n0", sq, -1, 1, 1'b1);
        mk_stream(32'(MAXW + 1), 0, 4);
        run_scenario("s3_big", sq, -1, 0, 1'b0);
        mk_stream(32'h0100_0001, 0, 4);
        run_scenario("s3_bighi", sq, -1, 1, 1'b0);
        run_scenario("s4_ferr", s1, 10, 1, 1'b0);

        // Reset in the middle of a load, then a clean load.
        do_reset;
        wb = wq_a.size();
        for (int i = 0; i < 6; i++) begin
            rx_valid = 1'b1; rx_data = s1[i];
            tick;
        end
        rx_valid = 1'b0;
        repeat (2) tick;
        chk("s6.partial_no_write", 64'(wq_a.size() - wb), 64'd0);
        chk("s6.partial_no_run", 64'({cpu_run, load_err}), 64'd0);
        run_scenario("s6_after_rst", s1, -1, 2, 1'b0);
        run_scenario("s6_b2b", s1, -1, 0, 1'b0);

        mk_stream(32'(MAXW), MAXW, 0);
        run_scenario("max_words", sq, -1, 0, 1'b0);

        for (int r = 0; r < 12; r++) begin
            kind = $urandom_range(0, 3);
            n    = $urandom_range(1, 6);
            fe   = -1;
            case (kind)
                0: mk_stream(32'(n), n, 0);
                1: begin
                    mk_stream(32'(n), n, 0);
                    fe = $urandom_range(0, sq.size() - 1);
                end
                2: mk_stream(32'(MAXW + 1 + $urandom_range(0, 1000)), 0, 4);
                default: mk_stream(32'd0, 0, 0);
            endcase
            run_scenario($sformatf("rnd%0d_k%0d", r, kind), sq, fe, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
